// File: rtl/tlb_array_pkg.sv
// Shared types, sizes and helpers for the joint TLB and its lookup ports.
package tlb_array_pkg;

  localparam int TLB_ENTRIES = 32;
  localparam int TLB_IDXBITS = 5;

  localparam logic [1:0] OP_TLBR  = 2'd0;
  localparam logic [1:0] OP_TLBWI = 2'd1;
  localparam logic [1:0] OP_TLBWR = 2'd2;
  localparam logic [1:0] OP_TLBP  = 2'd3;

  // One half (even or odd page) of an entry: EntryLo without G.
  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } tlb_half_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic [11:0] mask;
    logic        g;
    tlb_half_t   lo0;
    tlb_half_t   lo1;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_PROBE  = 2'd2,
    ST_REPORT = 2'd3
  } tlb_state_t;

  function automatic tlb_half_t lo_to_half(input logic [31:0] lo);
    return {lo[25:6], lo[5:3], lo[2], lo[1]};
  endfunction

  function automatic logic [31:0] half_to_lo(input tlb_half_t h, input logic g);
    return {6'b0, h.pfn, h.c, h.d, h.v, g};
  endfunction

  // Entry hit test: masked VPN2 compare plus global-or-ASID qualification.
  function automatic logic entry_match(input tlb_entry_t e, input logic [18:0] vpn2,
                                       input logic [7:0] asid);
    return (((e.vpn2 ^ vpn2) & ~{7'b0, e.mask}) == 19'b0) && (e.g || (e.asid == asid));
  endfunction

endpackage

// File: rtl/tlb_array_match.sv
// Combinational translation of one virtual address against all entries:
// lowest matching index wins, then odd/even half select and paddr merge.
module tlb_array_match
  import tlb_array_pkg::*;
(
  input  tlb_entry_t  entries [TLB_ENTRIES],
  input  logic [31:0] vaddr,
  input  logic [7:0]  asid,
  output logic        hit,
  output logic [31:0] paddr,
  output logic        v,
  output logic        d,
  output logic [2:0]  c
);

  logic [11:0] sel_mask;
  tlb_half_t   sel_lo0;
  tlb_half_t   sel_lo1;
  logic [31:0] offmask;
  logic        odd;
  tlb_half_t   half;

  // Priority select: scanning downward leaves the lowest matching entry.
  always_comb begin
    hit      = 1'b0;
    sel_mask = '0;
    sel_lo0  = '0;
    sel_lo1  = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (entry_match(entries[i], vaddr[31:13], asid)) begin
        hit      = 1'b1;
        sel_mask = entries[i].mask;
        sel_lo0  = entries[i].lo0;
        sel_lo1  = entries[i].lo1;
      end
    end
  end

  // Page offset mask is {mask,13 ones} shifted right by one; the bit just
  // above it picks the odd half.
  always_comb begin
    offmask = {8'b0, sel_mask, 12'hFFF};
    odd     = |(vaddr & {offmask[30:0], 1'b1} & ~offmask);
    half    = odd ? sel_lo1 : sel_lo0;
    paddr   = ({half.pfn, 12'b0} & ~offmask) | (vaddr & offmask);
    v       = half.v;
    d       = half.d;
    c       = half.c;
  end

endmodule

// File: rtl/tlb_array.sv
// Joint TLB: entry storage, CP0 TLBR/TLBWI/TLBWR/TLBP handling and two
// independent single-cycle-latency lookup ports (instruction and data).
// Handshake: an op is taken when op_valid is high and op_busy is low; ops
// presented while op_busy is high are dropped. Lookup ports have no
// handshake: rvalid is req delayed by one cycle.
module tlb_array
  import tlb_array_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  output logic        op_busy,
  input  logic [31:0] index,
  input  logic [31:0] random,
  input  logic [31:0] entryhi,
  input  logic [31:0] entrylo0,
  input  logic [31:0] entrylo1,
  input  logic [11:0] mask,
  output logic        tlbr_we,
  output logic [31:0] tlbr_lo0,
  output logic [31:0] tlbr_lo1,
  output logic [31:0] tlbr_hi,
  output logic [11:0] tlbr_mask,
  output logic        tlbp_we,
  output logic [31:0] tlbp_index,
  input  logic        i_req,
  input  logic [31:0] i_vaddr,
  output logic        i_rvalid,
  output logic [31:0] i_paddr,
  output logic        i_miss,
  output logic        i_inv,
  output logic [2:0]  i_cattr,
  input  logic        d_req,
  input  logic [31:0] d_vaddr,
  output logic        d_rvalid,
  output logic [31:0] d_paddr,
  output logic        d_miss,
  output logic        d_inv,
  output logic        d_dirty,
  output logic [2:0]  d_cattr,
  output logic [1:0]  dbg_state
);

  tlb_entry_t             entries [TLB_ENTRIES];
  tlb_entry_t             new_entry;
  tlb_entry_t             rd_entry;
  tlb_state_t             state;
  logic                   op_accept;
  logic                   wr_en;
  logic [TLB_IDXBITS-1:0] wr_idx;
  logic [TLB_ENTRIES-1:0] probe_match;
  logic [TLB_ENTRIES-1:0] probe_vec;
  logic                   probe_hit;
  logic [TLB_IDXBITS-1:0] probe_idx;
  logic                   i_hit, i_v, i_d, d_hit, d_v, d_d;
  logic [31:0]            i_pa, d_pa;
  logic [2:0]             i_c, d_c;
  logic                   unused_bits;

  assign op_accept = op_valid && (state == ST_IDLE);
  assign wr_en     = op_accept && ((op_code == OP_TLBWI) || (op_code == OP_TLBWR));
  assign wr_idx    = (op_code == OP_TLBWI) ? index[TLB_IDXBITS-1:0] : random[TLB_IDXBITS-1:0];
  assign rd_entry  = entries[index[TLB_IDXBITS-1:0]];
  assign dbg_state = state;
  assign unused_bits = ^{index[31:TLB_IDXBITS], random[31:TLB_IDXBITS], entryhi[12:8],
                         entrylo0[31:26], entrylo1[31:26], i_d};

  // Entry image built from the CP0 registers for TLBWI/TLBWR.
  always_comb begin
    new_entry      = '0;
    new_entry.vpn2 = entryhi[31:13];
    new_entry.asid = entryhi[7:0];
    new_entry.mask = mask;
    new_entry.g    = entrylo0[0] & entrylo1[0];
    new_entry.lo0  = lo_to_half(entrylo0);
    new_entry.lo1  = lo_to_half(entrylo1);
  end

  // Entry storage; a write lands at the edge ending the op cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < TLB_ENTRIES; i++) entries[i] <= '0;
    end else if (wr_en) begin
      entries[wr_idx] <= new_entry;
    end
  end

  // Probe compare of every entry against EntryHi.
  always_comb begin
    probe_match = '0;
    for (int i = 0; i < TLB_ENTRIES; i++)
      probe_match[i] = entry_match(entries[i], entryhi[31:13], entryhi[7:0]);
  end

  // Lowest set bit of the latched probe vector.
  always_comb begin
    probe_hit = 1'b0;
    probe_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (probe_vec[i]) begin
        probe_hit = 1'b1;
        probe_idx = TLB_IDXBITS'(i);
      end
    end
  end

  // Op sequencer: TLBR reports next cycle, TLBP latches then reports a cycle later.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      op_busy    <= 1'b0;
      tlbr_we    <= 1'b0;
      tlbr_lo0   <= '0;
      tlbr_lo1   <= '0;
      tlbr_hi    <= '0;
      tlbr_mask  <= '0;
      tlbp_we    <= 1'b0;
      tlbp_index <= '0;
      probe_vec  <= '0;
    end else begin
      tlbr_we <= 1'b0;
      tlbp_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_accept && (op_code == OP_TLBR)) begin
            state     <= ST_READ;
            op_busy   <= 1'b1;
            tlbr_we   <= 1'b1;
            tlbr_lo0  <= half_to_lo(rd_entry.lo0, rd_entry.g);
            tlbr_lo1  <= half_to_lo(rd_entry.lo1, rd_entry.g);
            tlbr_hi   <= {rd_entry.vpn2, 5'b0, rd_entry.asid};
            tlbr_mask <= rd_entry.mask;
          end else if (op_accept && (op_code == OP_TLBP)) begin
            state     <= ST_PROBE;
            op_busy   <= 1'b1;
            probe_vec <= probe_match;
          end
        end
        ST_READ: begin
          state   <= ST_IDLE;
          op_busy <= 1'b0;
        end
        ST_PROBE: begin
          state      <= ST_REPORT;
          tlbp_we    <= 1'b1;
          tlbp_index <= probe_hit ? {{(32-TLB_IDXBITS){1'b0}}, probe_idx} : 32'h8000_0000;
        end
        default: begin
          state   <= ST_IDLE;
          op_busy <= 1'b0;
        end
      endcase
    end
  end

  tlb_array_match u_imatch (
    .entries (entries),
    .vaddr   (i_vaddr),
    .asid    (entryhi[7:0]),
    .hit     (i_hit),
    .paddr   (i_pa),
    .v       (i_v),
    .d       (i_d),
    .c       (i_c)
  );

  tlb_array_match u_dmatch (
    .entries (entries),
    .vaddr   (d_vaddr),
    .asid    (entryhi[7:0]),
    .hit     (d_hit),
    .paddr   (d_pa),
    .v       (d_v),
    .d       (d_d),
    .c       (d_c)
  );

  // Register lookup results; translation fields are zeroed on a miss.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i_rvalid <= 1'b0;
      i_paddr  <= '0;
      i_miss   <= 1'b0;
      i_inv    <= 1'b0;
      i_cattr  <= '0;
      d_rvalid <= 1'b0;
      d_paddr  <= '0;
      d_miss   <= 1'b0;
      d_inv    <= 1'b0;
      d_dirty  <= 1'b0;
      d_cattr  <= '0;
    end else begin
      i_rvalid <= i_req;
      d_rvalid <= d_req;
      if (i_req) begin
        i_miss  <= !i_hit;
        i_inv   <= i_hit && !i_v;
        i_paddr <= i_hit ? i_pa : '0;
        i_cattr <= i_hit ? i_c : '0;
      end
      if (d_req) begin
        d_miss  <= !d_hit;
        d_inv   <= d_hit && !d_v;
        d_paddr <= d_hit ? d_pa : '0;
        d_dirty <= d_hit && d_d;
        d_cattr <= d_hit ? d_c : '0;
      end
    end
  end

endmodule
